// File: rtl/div_pkg.sv
// div_pkg: shared states, result field offsets and handshake constants for the iterative divider
package div_pkg;
  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_FIX, DIV_DONE} div_state_e;
  localparam int QUO_LSB = 0;
  localparam logic DivStart = 1'b1;
  localparam logic DivStop = 1'b0;
  localparam logic DivResultReady = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  function automatic int rem_lsb(input int width);
    return width;
  endfunction
endpackage

// File: rtl/div_negate_cond.sv
// div_negate_cond: two's complement negation when en is set, pass-through otherwise
module div_negate_cond #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] value,
  input  logic             en,
  output logic [WIDTH-1:0] y
);
  assign y = en ? -value : value;
endmodule

// File: rtl/divider_iter_param.sv
// divider_iter_param: radix-2 restoring signed/unsigned divider, result packed as {remainder, quotient}
module divider_iter_param
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic               busy_o,
  output logic               ready_o,
  output logic               div_zero_o,
  output logic [2*WIDTH-1:0] result_o
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int REM_LSB = rem_lsb(WIDTH);
  div_state_e state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs, abs1, abs2, quo_fix, rem_fix;
  logic sgn, sign1, sign2, accept;
  logic [WIDTH:0] shifted, trial;
  assign accept = start_i == DivStart && !annul_i;
  // the stored remainder is always below the divisor, so the WIDTH+1-bit working value needs no extra stored bit
  assign shifted = {rem, quo[WIDTH-1]};
  assign trial = shifted - {1'b0, dvs};
  div_negate_cond #(.WIDTH(WIDTH)) u_abs1 (.value(opdata1_i), .en(signed_i & opdata1_i[WIDTH-1]), .y(abs1));
  div_negate_cond #(.WIDTH(WIDTH)) u_abs2 (.value(opdata2_i), .en(signed_i & opdata2_i[WIDTH-1]), .y(abs2));
  div_negate_cond #(.WIDTH(WIDTH)) u_quo_fix (.value(quo), .en(sgn & (sign1 ^ sign2)), .y(quo_fix));
  div_negate_cond #(.WIDTH(WIDTH)) u_rem_fix (.value(rem), .en(sgn & sign1), .y(rem_fix));
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= DIV_IDLE;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
      sgn <= 1'b0;
      sign1 <= 1'b0;
      sign2 <= 1'b0;
      busy_o <= 1'b0;
      ready_o <= DivResultNotReady;
      div_zero_o <= 1'b0;
      result_o <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (accept) begin
          sgn <= signed_i;
          sign1 <= signed_i & opdata1_i[WIDTH-1];
          sign2 <= signed_i & opdata2_i[WIDTH-1];
          if (opdata2_i == '0) begin
            state <= DIV_DONE;
            ready_o <= DivResultReady;
            div_zero_o <= 1'b1;
            result_o[REM_LSB +: WIDTH] <= opdata1_i;
            result_o[QUO_LSB +: WIDTH] <= '1;
          end else begin
            state <= DIV_BUSY;
            busy_o <= 1'b1;
            cnt <= '0;
            rem <= '0;
            quo <= abs1;
            dvs <= abs2;
          end
        end
        DIV_BUSY: if (annul_i) begin
          state <= DIV_IDLE;
          busy_o <= 1'b0;
        end else begin
          rem <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) state <= DIV_FIX;
        end
        DIV_FIX: begin
          state <= annul_i ? DIV_IDLE : DIV_DONE;
          busy_o <= 1'b0;
          if (!annul_i) begin
            ready_o <= DivResultReady;
            result_o[REM_LSB +: WIDTH] <= rem_fix;
            result_o[QUO_LSB +: WIDTH] <= quo_fix;
          end
        end
        DIV_DONE: if (start_i == DivStop) begin
          state <= DIV_IDLE;
          ready_o <= DivResultNotReady;
          div_zero_o <= 1'b0;
          result_o <= '0;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_iter_param.sv
// tb_divider_iter_param: directed-vector bench for the 32-bit and 8-bit divider instances
module tb_divider_iter_param;
  logic clk, rst_n;
  logic start, annul, sgn, busy, ready, dz;
  logic [31:0] op1, op2;
  logic [63:0] result;
  logic start8, annul8, sgn8, busy8, ready8, dz8;
  logic [7:0] op1_8, op2_8;
  logic [15:0] result8;
  int n_checks = 0;
  int n_fail = 0;
  divider_iter_param #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .annul_i(annul), .signed_i(sgn),
    .opdata1_i(op1), .opdata2_i(op2), .busy_o(busy), .ready_o(ready),
    .div_zero_o(dz), .result_o(result)
  );
  divider_iter_param #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start_i(start8), .annul_i(annul8), .signed_i(sgn8),
    .opdata1_i(op1_8), .opdata2_i(op2_8), .busy_o(busy8), .ready_o(ready8),
    .div_zero_o(dz8), .result_o(result8)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask
  task automatic run32(input string tag, input logic sg, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp, input logic exp_dz, input int hold);
    int lat, nb;
    lat = 0;
    nb = 0;
    @(negedge clk);
    start = 1'b1;
    sgn = sg;
    op1 = a;
    op2 = b;
    for (int n = 1; n <= 60 && !ready; n++) begin
      @(negedge clk);
      lat = n;
      if (busy) nb++;
    end
    check({tag, " latency"}, 64'(lat), exp_dz ? 64'd1 : 64'd34);
    check({tag, " busy cycles"}, 64'(nb), exp_dz ? 64'd0 : 64'd33);
    check({tag, " result"}, result, exp);
    check({tag, " div_zero"}, 64'(dz), 64'(exp_dz));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({tag, " hold result"}, result, exp);
      check({tag, " hold ready"}, 64'(ready), 64'd1);
    end
    start = 1'b0;
    @(negedge clk);
    check({tag, " release ready"}, 64'(ready), 64'd0);
    check({tag, " release result"}, result, 64'd0);
  endtask
  initial begin
    int lat;
    rst_n = 1'b0;
    {start, annul, sgn, start8, annul8, sgn8} = '0;
    op1 = '0;
    op2 = '0;
    op1_8 = '0;
    op2_8 = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 64'(busy), 64'd0);
    check("reset ready", 64'(ready), 64'd0);
    check("reset div_zero", 64'(dz), 64'd0);
    check("reset result", result, 64'd0);
    rst_n = 1'b1;
    run32("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, 1);
    run32("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0, 0);
    run32("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'd1, 32'hFFFF_FFFD}, 1'b0, 0);
    run32("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000}, 1'b0, 0);
    run32("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF}, 1'b0, 0);
    run32("divu min/max", 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'd0}, 1'b0, 0);
    run32("divu 1234/0", 1'b0, 32'h1234, 32'd0, {32'h1234, 32'hFFFF_FFFF}, 1'b1, 5);
    run32("div -20/0", 1'b1, 32'hFFFF_FFEC, 32'd0, {32'hFFFF_FFEC, 32'hFFFF_FFFF}, 1'b1, 0);
    // start together with annul in IDLE must not be accepted
    @(negedge clk);
    start = 1'b1;
    annul = 1'b1;
    op1 = 32'd50;
    op2 = 32'd5;
    repeat (3) @(negedge clk);
    check("start+annul busy", 64'(busy), 64'd0);
    check("start+annul ready", 64'(ready), 64'd0);
    start = 1'b0;
    annul = 1'b0;
    @(negedge clk);
    start = 1'b1;
    sgn = 1'b0;
    op1 = 32'd1000;
    op2 = 32'd3;
    repeat (10) @(negedge clk);
    check("annul pre busy", 64'(busy), 64'd1);
    annul = 1'b1;
    start = 1'b0;
    @(negedge clk);
    check("annul busy", 64'(busy), 64'd0);
    check("annul ready", 64'(ready), 64'd0);
    annul = 1'b0;
    @(negedge clk);
    check("annul idle ready", 64'(ready), 64'd0);
    start = 1'b1;
    op1 = 32'd9;
    op2 = 32'd3;
    lat = 0;
    for (int n = 1; n <= 60 && !ready; n++) begin
      @(negedge clk);
      lat = n;
    end
    check("after annul latency", 64'(lat), 64'd34);
    check("after annul result", result, {32'd0, 32'd3});
    start = 1'b0;
    @(negedge clk);
    start = 1'b1;
    op1 = 32'd1000;
    op2 = 32'd3;
    repeat (6) @(negedge clk);
    check("pre reset busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async reset busy", 64'(busy), 64'd0);
    check("async reset ready", 64'(ready), 64'd0);
    check("async reset result", result, 64'd0);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post reset ready", 64'(ready), 64'd0);
    check("post reset busy", 64'(busy), 64'd0);
    start8 = 1'b1;
    sgn8 = 1'b1;
    op1_8 = 8'h80;
    op2_8 = 8'd3;
    lat = 0;
    for (int n = 1; n <= 30 && !ready8; n++) begin
      @(negedge clk);
      lat = n;
    end
    check("w8 latency", 64'(lat), 64'd10);
    check("w8 result", 64'(result8), 64'(16'hFED6));
    check("w8 div_zero", 64'(dz8), 64'd0);
    start8 = 1'b0;
    @(negedge clk);
    check("w8 release result", 64'(result8), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
